// File: rtl/weight_update_node_from_hidden_layer.sv
// rtl/weight_update_node_from_hidden_layer.sv - SGD update of one hidden node's incoming weights
//
// Purpose: on an accepted delta, computes scale = delta * LEARNING_RATE, then for every
// incoming weight k (activations 0..N-1 plus the bias at k = N):
//   w_new = w - scale * act[k]
// and writes w_new back to the weight RAM. Both RAMs have one cycle read latency.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_valid, i_delta_node    delta handshake (accepted only while o_ready)
//   o_ready                  high only when idle
//   o_act_addr, i_act_data   activation RAM read port
//   o_weight_addr            weight RAM address (shared by read and write)
//   i_weight_data            weight RAM read data
//   o_weight_we/_wdata       one-cycle weight write
//   o_done                   one-cycle pulse after the last weight write
//
// Build option: WEIGHT_CLIP_EN clamps the written weight magnitude to WEIGHT_CLIP.

module multiplier_floating_point32 #(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic [31:0] pipe [LATENCY];

    // Denormals flush to zero, round to nearest even, overflow saturates to infinity.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic               s;
        logic [47:0]        p;
        logic signed [9:0]  e;
        logic [23:0]        m;
        logic               g;
        logic               st;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'b0};
        p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
        e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
        end else begin
            m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            m = 24'd0; e = e + 10'sd1;
        end
        if (e <= 10'sd0) return {s, 31'b0};
        if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
        return {s, e[7:0], m[22:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= 32'b0;
        end else begin
            pipe[0] <= fmul(a, b);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LATENCY-1];
endmodule

module adder_floating_point32 #(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic [31:0] pipe [LATENCY];

    // Three extra bits (guard, round, sticky) below the mantissa; exact cancellation gives +0.
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]        p;
        logic [31:0]        q;
        logic [26:0]        mp;
        logic [26:0]        mq;
        logic [27:0]        sum;
        logic [7:0]         d;
        logic signed [9:0]  e;
        logic [23:0]        m;
        logic               g;
        logic               st;
        logic               found;
        int                 lz;
        if (x[30:23] == 8'd0) return (y[30:23] == 8'd0) ? 32'b0 : y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:0] >= y[30:0]) begin
            p = x; q = y;
        end else begin
            p = y; q = x;
        end
        d  = p[30:23] - q[30:23];
        mp = {1'b1, p[22:0], 3'b0};
        mq = {1'b1, q[22:0], 3'b0};
        if (d > 8'd26) begin
            mq = 27'd1;
        end else begin
            mq = ({1'b1, q[22:0], 3'b0}) >> d;
            if ((mq << d) != {1'b1, q[22:0], 3'b0}) mq[0] = 1'b1;
        end
        e = $signed({2'b0, p[30:23]});
        if (p[31] == q[31]) begin
            sum = {1'b0, mp} + {1'b0, mq};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 10'sd1;
            end
        end else begin
            sum = {1'b0, mp} - {1'b0, mq};
            if (sum == 28'd0) return 32'b0;
            lz = 0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found && sum[i]) found = 1'b1;
                else if (!found) lz++;
            end
            sum = sum << lz;
            e   = e - 10'(lz);
        end
        m  = {1'b0, sum[25:3]};
        g  = sum[2];
        st = |sum[1:0];
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            m = 24'd0; e = e + 10'sd1;
        end
        if (e <= 10'sd0) return {p[31], 31'b0};
        if (e >= 10'sd255) return {p[31], 8'hFF, 23'b0};
        return {p[31], e[7:0], m[22:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= 32'b0;
        end else begin
            pipe[0] <= fadd(a, b);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LATENCY-1];
endmodule

module weight_update_node_from_hidden_layer #(
    parameter int                    DATA_WIDTH          = 32,
    parameter int                    ADDRESS_WIDTH       = 11,
    parameter logic [DATA_WIDTH-1:0] LEARNING_RATE       = 32'h3A83126F,
    parameter int                    ADDRESS_NODE        = 0,
    parameter int                    NUMBER_OF_BACK_NODE = 32,
    parameter logic [DATA_WIDTH-1:0] WEIGHT_CLIP         = 32'h40000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH-1:0]    i_delta_node,
    output logic                     o_ready,
    output logic [ADDRESS_WIDTH-1:0] o_act_addr,
    input  logic [DATA_WIDTH-1:0]    i_act_data,
    output logic [ADDRESS_WIDTH-1:0] o_weight_addr,
    input  logic [DATA_WIDTH-1:0]    i_weight_data,
    output logic                     o_weight_we,
    output logic [DATA_WIDTH-1:0]    o_weight_wdata,
    output logic                     o_done
);
    localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(ADDRESS_NODE * (NUMBER_OF_BACK_NODE + 1));
    localparam logic [ADDRESS_WIDTH-1:0] K_LAST = ADDRESS_WIDTH'(NUMBER_OF_BACK_NODE);
    localparam logic [DATA_WIDTH-1:0]    ONE = 32'h3F800000;
    // The accepting IDLE cycle already feeds the multiplier, so SCALE itself lasts 7 cycles.
    localparam logic [2:0]               SCALE_LAST = 3'd6;
    localparam logic [2:0]               PHASE_LAST = 3'd7;

    typedef enum logic [2:0] {IDLE, SCALE, READ, MUL, ADD, WRITE, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [2:0]               cnt;
    logic [ADDRESS_WIDTH-1:0] k;
    logic [DATA_WIDTH-1:0]    delta_q;
    logic [DATA_WIDTH-1:0]    scale_q;
    logic [DATA_WIDTH-1:0]    act_q;
    logic [DATA_WIDTH-1:0]    weight_q;
    logic [DATA_WIDTH-1:0]    grad_q;
    logic [DATA_WIDTH-1:0]    wnew_q;
    logic [DATA_WIDTH-1:0]    act_sel;
    logic [DATA_WIDTH-1:0]    mul_a;
    logic [DATA_WIDTH-1:0]    mul_b;
    logic [DATA_WIDTH-1:0]    mul_result;
    logic [DATA_WIDTH-1:0]    add_result;
    logic [DATA_WIDTH-1:0]    w_final;

    assign act_sel = (k == K_LAST) ? ONE : i_act_data;

    // Operands are held for the whole phase, so the pipe output at the last phase
    // cycle is the result of the operands presented on the first one.
    assign mul_a = (state == MUL) ? scale_q : ((state == SCALE) ? delta_q : i_delta_node);
    assign mul_b = (state == MUL) ? ((cnt == 3'd0) ? act_sel : act_q) : LEARNING_RATE;

    multiplier_floating_point32 #(.LATENCY(7)) u_mul (
        .clk(clk), .rst(rst), .a(mul_a), .b(mul_b), .result(mul_result)
    );

    adder_floating_point32 #(.LATENCY(7)) u_add (
        .clk(clk), .rst(rst), .a(weight_q), .b({~grad_q[31], grad_q[30:0]}), .result(add_result)
    );

`ifdef WEIGHT_CLIP_EN
    assign w_final = (wnew_q[30:0] > WEIGHT_CLIP[30:0]) ? {wnew_q[31], WEIGHT_CLIP[30:0]} : wnew_q;
`else
    logic unused_clip;
    assign unused_clip = ^WEIGHT_CLIP;
    assign w_final = wnew_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = SCALE;
            SCALE:   if (cnt == SCALE_LAST) state_next = READ;
            READ:    state_next = MUL;
            MUL:     if (cnt == PHASE_LAST) state_next = ADD;
            ADD:     if (cnt == PHASE_LAST) state_next = WRITE;
            WRITE:   state_next = (k == K_LAST) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready        = (state == IDLE);
        o_done         = (state == DONE);
        o_weight_we    = (state == WRITE);
        o_act_addr     = '0;
        o_weight_addr  = '0;
        o_weight_wdata = '0;
        if (state == READ || state == MUL || state == ADD || state == WRITE) begin
            o_act_addr    = k;
            o_weight_addr = BASE + k;
        end
        if (state == WRITE) o_weight_wdata = w_final;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 3'd0;
            k        <= '0;
            delta_q  <= '0;
            scale_q  <= '0;
            act_q    <= '0;
            weight_q <= '0;
            grad_q   <= '0;
            wnew_q   <= '0;
        end else begin
            cnt <= (state_next != state) ? 3'd0 : cnt + 3'd1;
            case (state)
                IDLE: if (i_valid) begin
                    delta_q <= i_delta_node;
                    k       <= '0;
                end
                SCALE: if (cnt == SCALE_LAST) scale_q <= mul_result;
                MUL: begin
                    // RAM data for the address driven in READ is valid on the first MUL cycle.
                    if (cnt == 3'd0) begin
                        act_q    <= act_sel;
                        weight_q <= i_weight_data;
                    end
                    if (cnt == PHASE_LAST) grad_q <= mul_result;
                end
                ADD:   if (cnt == PHASE_LAST) wnew_q <= add_result;
                WRITE: k <= k + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_update_node_from_hidden_layer.sv
// tb/tb_weight_update_node_from_hidden_layer.sv - scoreboard bench for the weight update node
module tb_weight_update_node_from_hidden_layer;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_delta_node;
    logic        o_ready;
    logic [10:0] o_act_addr;
    logic [31:0] i_act_data;
    logic [10:0] o_weight_addr;
    logic [31:0] i_weight_data;
    logic        o_weight_we;
    logic [31:0] o_weight_wdata;
    logic        o_done;

    always #5 clk = ~clk;

    weight_update_node_from_hidden_layer #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(11), .LEARNING_RATE(32'h3F000000),
        .ADDRESS_NODE(1), .NUMBER_OF_BACK_NODE(2), .WEIGHT_CLIP(32'h40000000)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_delta_node(i_delta_node),
        .o_ready(o_ready), .o_act_addr(o_act_addr), .i_act_data(i_act_data),
        .o_weight_addr(o_weight_addr), .i_weight_data(i_weight_data),
        .o_weight_we(o_weight_we), .o_weight_wdata(o_weight_wdata), .o_done(o_done)
    );

    logic [31:0] act_mem [0:15];
    logic [31:0] w_mem   [0:15];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    int          done_q [$];

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        i_act_data    <= act_mem[o_act_addr[3:0]];
        i_weight_data <= w_mem[o_weight_addr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_weight_we) begin
                if (exp_data_q.size() == 0) check("write_unexpected", {31'b0, o_weight_we}, 32'd0);
                else begin
                    check("write_addr", {21'b0, o_weight_addr}, exp_addr_q.pop_front());
                    check("write_data", o_weight_wdata, exp_data_q.pop_front());
                end
            end
            if (o_done) begin
                done_cnt++;
                if (done_q.size() == 0) check("done_unexpected", {31'b0, o_done}, 32'd0);
                else check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
    end

    task automatic load(input logic [31:0] w0, w1, w2, a0, a1);
        w_mem[3] = w0; w_mem[4] = w1; w_mem[5] = w2;
        act_mem[0] = a0; act_mem[1] = a1;
    endtask

    task automatic expect_writes(input logic [31:0] d0, d1, d2);
        exp_addr_q.push_back(32'd3); exp_data_q.push_back(d0);
        exp_addr_q.push_back(32'd4); exp_data_q.push_back(d1);
        exp_addr_q.push_back(32'd5); exp_data_q.push_back(d2);
    endtask

    task automatic start_op(input logic [31:0] d, input bit want_done);
        @(negedge clk);
        check("ready_before_start", {31'b0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_delta_node = d;
        acc_cyc = cyc;
        if (want_done) done_q.push_back(cyc + 62);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_done();
        int  start;
        bit  seen;
        start = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            if (done_cnt > start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'(done_cnt), 32'(start + 1));
        repeat (4) @(negedge clk);
        check("pending_writes", 32'(exp_data_q.size()), 32'd0);
        check("ready_after_done", {31'b0, o_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            act_mem[i] = 32'h0;
            w_mem[i] = 32'h0;
        end
        rst = 1'b1;
        i_valid = 1'b0;
        i_delta_node = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_we", {31'b0, o_weight_we}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_act_addr", {21'b0, o_act_addr}, 32'd0);
        check("rst_weight_addr", {21'b0, o_weight_addr}, 32'd0);
        check("rst_wdata", o_weight_wdata, 32'd0);
        rst = 1'b0;

        // scale = 2.0*0.5 = 1.0; w - act
        load(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h00000000);
        expect_writes(32'h3F000000, 32'h3F800000, 32'h00000000);
        start_op(32'h40000000, 1'b1);
        wait_done();

        // a second delta arriving mid-operation is dropped
        load(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h00000000);
        expect_writes(32'h3F000000, 32'h3F800000, 32'h00000000);
        start_op(32'h40000000, 1'b1);
        while (cyc < acc_cyc + 10) @(negedge clk);
        i_valid = 1'b1;
        i_delta_node = 32'hC0000000;
        check("ready_busy", {31'b0, o_ready}, 32'd0);
        repeat (3) @(negedge clk);
        i_valid = 1'b0;
        wait_done();

        // reset during ADD of k=1: only the k=0 write happens
        load(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h00000000);
        exp_addr_q.push_back(32'd3);
        exp_data_q.push_back(32'h3F000000);
        start_op(32'h40000000, 1'b0);
        while (cyc < acc_cyc + 38) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", {31'b0, o_ready}, 32'd1);
        check("midrst_we", {31'b0, o_weight_we}, 32'd0);
        check("midrst_weight_addr", {21'b0, o_weight_addr}, 32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_pending", 32'(exp_data_q.size()), 32'd0);
        load(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h00000000);
        expect_writes(32'h3F000000, 32'h3F800000, 32'h00000000);
        start_op(32'h40000000, 1'b1);
        wait_done();

        // zero delta rewrites the original weights
        load(32'h3F800000, 32'hC0400000, 32'h3E800000, 32'h3F000000, 32'hBF800000);
        expect_writes(32'h3F800000, 32'hC0400000, 32'h3E800000);
        start_op(32'h00000000, 1'b1);
        wait_done();

        // scale = -8*0.5 = -4: 1+4 = 5, 1-4 = -3, bias 1+4 = 5
        load(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000);
`ifdef WEIGHT_CLIP_EN
        expect_writes(32'h40000000, 32'hC0000000, 32'h40000000);
`else
        expect_writes(32'h40A00000, 32'hC0400000, 32'h40A00000);
`endif
        start_op(32'hC1000000, 1'b1);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
